// File: rtl/lif_neuron_win.sv
// Leaky integrate-and-fire output neuron with refractory period and windowed
// spike counting.
//
// Ports:
//   clk            rising-edge clock for all state
//   rst            synchronous reset, active-high
//   en             cycle enable; all state holds when low
//   spiking_value  signed synaptic input for this cycle
//   out_spike      one-cycle spike pulse (registered)
//   spike_cnt      spikes in the last completed window, held until next window end
//   window_done    one-cycle pulse marking the window end; spike_cnt updates with it
//   potential      membrane potential (observability)
module lif_neuron_win #(
  parameter int unsigned DATA_W         = 16,
  parameter int          THRESHOLD      = 64,
  parameter int unsigned LEAK_SHIFT     = 4,
  parameter int unsigned REFRACT_CYCLES = 50,
  parameter int unsigned T_WINDOW       = 250,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] spiking_value,
  output logic                     out_spike,
  output logic        [CNT_W-1:0]  spike_cnt,
  output logic                     window_done,
  output logic signed [DATA_W-1:0] potential
);

  localparam int unsigned SUM_W  = DATA_W + 2;
  localparam int unsigned REFR_W = (REFRACT_CYCLES != 0) ? $clog2(REFRACT_CYCLES + 1) : 1;
  localparam int unsigned WIN_W  = $clog2(T_WINDOW);

  localparam logic signed [SUM_W-1:0] THR     = SUM_W'(THRESHOLD);
  localparam logic signed [SUM_W-1:0] SAT_MAX = {3'b000, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {3'b111, {(DATA_W-1){1'b0}}};
  localparam logic [REFR_W-1:0]       REFR_LOAD = REFR_W'(REFRACT_CYCLES);
  localparam logic [WIN_W-1:0]        WIN_LAST  = WIN_W'(T_WINDOW - 1);

  typedef enum logic {
    ST_INTEGRATE,
    ST_REFRACTORY
  } state_t;

  state_t                     state_q, state_d;
  logic signed [DATA_W-1:0]   pot_q, pot_d;
  logic        [REFR_W-1:0]   refr_q, refr_d;
  logic        [WIN_W-1:0]    win_q, win_d;
  logic        [CNT_W-1:0]    acc_q, acc_d;
  logic        [CNT_W-1:0]    spike_cnt_d;
  logic                       out_spike_d;
  logic                       window_done_d;

  logic signed [DATA_W-1:0]   leak_c;
  logic signed [SUM_W-1:0]    sum_wide_c;
  logic signed [DATA_W-1:0]   sum_sat_c;
  logic                       fire_c;
  logic                       fired;
  logic        [CNT_W-1:0]    acc_next;

  // Leak term; a zero shift means no leak rather than subtracting the whole potential.
  if (LEAK_SHIFT == 0) begin : g_no_leak
    assign leak_c = '0;
  end else begin : g_leak
    assign leak_c = pot_q >>> LEAK_SHIFT;
  end

  // Two guard bits hold any potential - leak + input without overflow before clamping.
  assign sum_wide_c = SUM_W'(pot_q) - SUM_W'(leak_c) + SUM_W'(spiking_value);

  always_comb begin
    if (sum_wide_c > SAT_MAX) begin
      sum_sat_c = SAT_MAX[DATA_W-1:0];
    end else if (sum_wide_c < SAT_MIN) begin
      sum_sat_c = SAT_MIN[DATA_W-1:0];
    end else begin
      sum_sat_c = sum_wide_c[DATA_W-1:0];
    end
  end

  assign fire_c = (SUM_W'(sum_sat_c) >= THR);

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    pot_d         = pot_q;
    refr_d        = refr_q;
    win_d         = win_q;
    acc_d         = acc_q;
    spike_cnt_d   = spike_cnt;
    out_spike_d   = 1'b0;
    window_done_d = 1'b0;
    fired         = 1'b0;
    acc_next      = acc_q;

    if (en) begin
      case (state_q)
        ST_INTEGRATE: begin
          if (fire_c) begin
            fired = 1'b1;
            pot_d = '0;
            if (REFRACT_CYCLES != 0) begin
              state_d = ST_REFRACTORY;
              refr_d  = REFR_LOAD;
            end
          end else begin
            pot_d = sum_sat_c;
          end
        end
        ST_REFRACTORY: begin
          pot_d  = '0;
          refr_d = refr_q - REFR_W'(1);
          if (refr_q == REFR_W'(1)) begin
            state_d = ST_INTEGRATE;
          end
        end
        default: state_d = ST_INTEGRATE;
      endcase

      out_spike_d = fired;
      if (fired && (acc_q != {CNT_W{1'b1}})) begin
        acc_next = acc_q + CNT_W'(1);
      end

      // Window end publishes the count (including this cycle's spike) and starts clean.
      if (win_q == WIN_LAST) begin
        spike_cnt_d   = acc_next;
        window_done_d = 1'b1;
        acc_d         = '0;
        win_d         = '0;
        pot_d         = '0;
        state_d       = ST_INTEGRATE;
        refr_d        = '0;
      end else begin
        acc_d = acc_next;
        win_d = win_q + WIN_W'(1);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INTEGRATE;
      pot_q       <= '0;
      refr_q      <= '0;
      win_q       <= '0;
      acc_q       <= '0;
      spike_cnt   <= '0;
      out_spike   <= 1'b0;
      window_done <= 1'b0;
    end else begin
      state_q     <= state_d;
      pot_q       <= pot_d;
      refr_q      <= refr_d;
      win_q       <= win_d;
      acc_q       <= acc_d;
      spike_cnt   <= spike_cnt_d;
      out_spike   <= out_spike_d;
      window_done <= window_done_d;
    end
  end

  assign potential = pot_q;

endmodule

// File: tb/tb_lif_neuron_win.sv
// Testbench for lif_neuron_win: three differently parameterised instances
// share one stimulus stream and are checked against a behavioural model.
module tb_lif_neuron_win;

  localparam int NI = 3;
  // Per-instance parameters: 0 = defaults, 1 = no leak/refractory short window,
  // 2 = max threshold, tiny window, 2-bit counter.
  localparam int TH   [NI] = '{64, 64, 32767};
  localparam int LS   [NI] = '{4, 0, 2};
  localparam int RC   [NI] = '{50, 0, 0};
  localparam int TW   [NI] = '{250, 10, 7};
  localparam int CMAX [NI] = '{255, 255, 3};

  logic clk = 1'b0;
  logic rst, en;
  logic signed [15:0] sv;

  logic              spk0, spk1, spk2, wd0, wd1, wd2;
  logic [7:0]        cnt0, cnt1;
  logic [1:0]        cnt2;
  logic signed [15:0] pot0, pot1, pot2;

  logic              spk_o [NI];
  logic              wd_o  [NI];
  logic [7:0]        cnt_o [NI];
  logic signed [15:0] pot_o [NI];

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  int m_pot [NI];
  int m_refr[NI];
  int m_win [NI];
  int m_acc [NI];
  int m_cnt [NI];
  bit m_spk [NI];
  bit m_wd  [NI];

  always #5 clk = ~clk;

  lif_neuron_win #(.DATA_W(16), .THRESHOLD(64), .LEAK_SHIFT(4), .REFRACT_CYCLES(50),
                   .T_WINDOW(250), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .spiking_value(sv),
    .out_spike(spk0), .spike_cnt(cnt0), .window_done(wd0), .potential(pot0));

  lif_neuron_win #(.DATA_W(16), .THRESHOLD(64), .LEAK_SHIFT(0), .REFRACT_CYCLES(0),
                   .T_WINDOW(10), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .spiking_value(sv),
    .out_spike(spk1), .spike_cnt(cnt1), .window_done(wd1), .potential(pot1));

  lif_neuron_win #(.DATA_W(16), .THRESHOLD(32767), .LEAK_SHIFT(2), .REFRACT_CYCLES(0),
                   .T_WINDOW(7), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .spiking_value(sv),
    .out_spike(spk2), .spike_cnt(cnt2), .window_done(wd2), .potential(pot2));

  assign spk_o[0] = spk0;  assign spk_o[1] = spk1;  assign spk_o[2] = spk2;
  assign wd_o[0]  = wd0;   assign wd_o[1]  = wd1;   assign wd_o[2]  = wd2;
  assign cnt_o[0] = cnt0;  assign cnt_o[1] = cnt1;  assign cnt_o[2] = 8'(cnt2);
  assign pot_o[0] = pot0;  assign pot_o[1] = pot1;  assign pot_o[2] = pot2;

  function automatic int sat16(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  // One enabled/disabled/reset cycle of the neuron, straight from the behavioural rules.
  task automatic model_step(input bit r, input bit e, input int v);
    for (int k = 0; k < NI; k++) begin
      if (r) begin
        m_pot[k] = 0; m_refr[k] = 0; m_win[k] = 0; m_acc[k] = 0;
        m_cnt[k] = 0; m_spk[k] = 0; m_wd[k] = 0;
      end else if (!e) begin
        m_spk[k] = 0;
        m_wd[k]  = 0;
      end else begin
        bit fired = 0;
        if (m_refr[k] == 0) begin
          int leak = (LS[k] == 0) ? 0 : (m_pot[k] >>> LS[k]);
          int sum  = sat16(m_pot[k] - leak + v);
          if (sum >= TH[k]) begin
            fired    = 1;
            m_pot[k] = 0;
            m_refr[k] = RC[k];
          end else begin
            m_pot[k] = sum;
          end
        end else begin
          m_pot[k]  = 0;
          m_refr[k] = m_refr[k] - 1;
        end
        m_spk[k] = fired;
        if (fired && m_acc[k] < CMAX[k]) m_acc[k]++;
        if (m_win[k] == TW[k] - 1) begin
          m_cnt[k] = m_acc[k];
          m_wd[k]  = 1;
          m_acc[k] = 0;
          m_win[k] = 0;
          m_pot[k] = 0;
          m_refr[k] = 0;
        end else begin
          m_wd[k] = 0;
          m_win[k]++;
        end
      end
    end
  endtask

  // Apply inputs, clock once, advance the model, settle past the edge.
  task automatic tick(input bit r, input bit e, input int v);
    rst = r;
    en  = e;
    sv  = 16'(v);
    @(posedge clk);
    model_step(r, e, v);
    #1;
  endtask

  task automatic test_reset();
    tick(1, 0, 0);
    tick(1, 1, 1000);
    for (int k = 0; k < NI; k++) begin
      n_vec++;
      if (pot_o[k] !== 16'sd0 || spk_o[k] !== 1'b0 || wd_o[k] !== 1'b0 || cnt_o[k] !== 8'd0) begin
        n_err++;
        $display("FAIL reset[%0d]: pot=%0d spk=%0b wd=%0b cnt=%0d, required all 0",
                 k, pot_o[k], spk_o[k], wd_o[k], cnt_o[k]);
      end
    end
  endtask

  task automatic test_accumulate();
    int exp_pot [4] = '{16, 32, 48, 0};
    bit exp_spk [4] = '{0, 0, 0, 1};
    tick(1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, 16);
      n_vec++;
      if (pot_o[1] !== 16'(exp_pot[i]) || spk_o[1] !== exp_spk[i]) begin
        n_err++;
        $display("FAIL accumulate step %0d: pot=%0d spk=%0b, required pot=%0d spk=%0b",
                 i, pot_o[1], spk_o[1], exp_pot[i], exp_spk[i]);
      end
    end
  endtask

  task automatic test_leak();
    int exp_pot [4] = '{30, 29, 28, 27};
    tick(1, 0, 0);
    tick(0, 1, 32);
    n_vec++;
    if (pot_o[0] !== 16'sd32) begin
      n_err++;
      $display("FAIL leak_preload: pot=%0d, required 32", pot_o[0]);
    end
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, 0);
      n_vec++;
      if (pot_o[0] !== 16'(exp_pot[i])) begin
        n_err++;
        $display("FAIL leak step %0d: pot=%0d, required %0d", i, pot_o[0], exp_pot[i]);
      end
    end
  endtask

  task automatic test_refractory();
    tick(1, 0, 0);
    tick(0, 1, 100);
    n_vec++;
    if (spk_o[0] !== 1'b1) begin
      n_err++;
      $display("FAIL refract_first_spike: spk=%0b, required 1", spk_o[0]);
    end
    for (int i = 1; i <= 51; i++) begin
      bit exp_spk = (i == 51);
      tick(0, 1, 100);
      n_vec++;
      if (spk_o[0] !== exp_spk || pot_o[0] !== 16'sd0) begin
        n_err++;
        $display("FAIL refract cycle %0d: spk=%0b pot=%0d, required spk=%0b pot=0",
                 i, spk_o[0], pot_o[0], exp_spk);
      end
    end
  endtask

  task automatic test_saturation();
    tick(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, -32768);
      n_vec++;
      if (pot_o[2] !== 16'sh8000 || spk_o[2] !== 1'b0) begin
        n_err++;
        $display("FAIL neg_sat step %0d: pot=%0d spk=%0b, required pot=-32768 spk=0",
                 i, pot_o[2], spk_o[2]);
      end
    end
    // Saturated-high sum meets the max threshold every cycle; the 2-bit count saturates.
    tick(1, 0, 0);
    for (int i = 1; i <= 7; i++) begin
      tick(0, 1, 32767);
      n_vec++;
      if (spk_o[2] !== 1'b1 || wd_o[2] !== (i == 7) || cnt_o[2] !== ((i == 7) ? 8'd3 : 8'd0)) begin
        n_err++;
        $display("FAIL pos_sat cycle %0d: spk=%0b wd=%0b cnt=%0d, required spk=1 wd=%0b cnt=%0d",
                 i, spk_o[2], wd_o[2], cnt_o[2], (i == 7), (i == 7) ? 3 : 0);
      end
    end
  endtask

  task automatic test_window();
    tick(1, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      tick(0, 1, 64);
      n_vec++;
      if (spk_o[1] !== 1'b1 || wd_o[1] !== (i == 10) || cnt_o[1] !== ((i == 10) ? 8'd10 : 8'd0)) begin
        n_err++;
        $display("FAIL window cycle %0d: spk=%0b wd=%0b cnt=%0d, required spk=1 wd=%0b cnt=%0d",
                 i, spk_o[1], wd_o[1], cnt_o[1], (i == 10), (i == 10) ? 10 : 0);
      end
    end
    tick(0, 1, 0);
    n_vec++;
    if (wd_o[1] !== 1'b0 || cnt_o[1] !== 8'd10) begin
      n_err++;
      $display("FAIL window_hold: wd=%0b cnt=%0d, required wd=0 cnt=10", wd_o[1], cnt_o[1]);
    end
  endtask

  task automatic test_en_hold();
    tick(1, 0, 0);
    tick(0, 1, 16);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 500);
      n_vec++;
      if (pot_o[1] !== 16'sd16 || spk_o[1] !== 1'b0 || wd_o[1] !== 1'b0) begin
        n_err++;
        $display("FAIL en_hold step %0d: pot=%0d spk=%0b wd=%0b, required pot=16 spk=0 wd=0",
                 i, pot_o[1], spk_o[1], wd_o[1]);
      end
    end
    tick(0, 1, 16);
    n_vec++;
    if (pot_o[1] !== 16'sd32) begin
      n_err++;
      $display("FAIL en_resume: pot=%0d, required 32", pot_o[1]);
    end
  endtask

  task automatic test_reset_mid();
    int nen = 0;
    // Leave instance 0 refractory and instance 1 holding a completed count.
    tick(1, 0, 0);
    for (int i = 0; i < 10; i++) tick(0, 1, 64);
    tick(0, 1, 100);
    tick(0, 0, 100);
    tick(0, 1, 100);
    tick(1, 1, 100);
    for (int k = 0; k < NI; k++) begin
      n_vec++;
      if (pot_o[k] !== 16'sd0 || spk_o[k] !== 1'b0 || wd_o[k] !== 1'b0 || cnt_o[k] !== 8'd0) begin
        n_err++;
        $display("FAIL reset_mid[%0d]: pot=%0d spk=%0b wd=%0b cnt=%0d, required all 0",
                 k, pot_o[k], spk_o[k], wd_o[k], cnt_o[k]);
      end
    end
    for (int i = 0; i < 40 && nen < 10; i++) begin
      bit e = (i % 2 == 0) ? 1'b1 : 1'($urandom);
      tick(0, e, 5);
      if (e) nen++;
      n_vec++;
      if (wd_o[1] !== (e && nen == 10)) begin
        n_err++;
        $display("FAIL reset_mid_window en_count %0d: wd=%0b, required %0b", nen, wd_o[1], (e && nen == 10));
      end
    end
    n_vec++;
    if (nen != 10) begin
      n_err++;
      $display("FAIL reset_mid_budget: en_count=%0d, required 10", nen);
    end
  endtask

  task automatic test_random();
    tick(1, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      bit r = ($urandom_range(0, 199) == 0);
      bit e = ($urandom_range(0, 3) != 0);
      int v;
      case ($urandom_range(0, 3))
        0: v = int'($urandom_range(0, 60)) - 20;
        1: v = int'($urandom_range(0, 100));
        2: v = int'($signed(16'($urandom)));
        default: v = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
      endcase
      tick(r, e, v);
      for (int k = 0; k < NI; k++) begin
        n_vec++;
        if (pot_o[k] !== 16'(m_pot[k]) || spk_o[k] !== m_spk[k] || wd_o[k] !== m_wd[k] ||
            cnt_o[k] !== 8'(m_cnt[k])) begin
          n_err++;
          $display("FAIL random[%0d] cycle %0d: pot=%0d spk=%0b wd=%0b cnt=%0d, required pot=%0d spk=%0b wd=%0b cnt=%0d",
                   k, c, pot_o[k], spk_o[k], wd_o[k], cnt_o[k], m_pot[k], m_spk[k], m_wd[k], m_cnt[k]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    sv  = '0;
    test_reset();
    test_accumulate();
    test_leak();
    test_refractory();
    test_saturation();
    test_window();
    test_en_hold();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
